// File: rtl/seq_alu_if.sv
// Operand/result bundle for seq_alu_unit; the ovf wire exists only when ALU_OVF_FLAG_EN is defined.
// Handshake: operands are taken on a clk edge where start=1 and no MUL is in flight; done pulses when results land.
interface seq_alu_if #(parameter int WIDTH = 4);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             c_in;
  logic [2:0]       op;
  logic             m;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] s;
  logic [WIDTH-1:0] s_hi;
  logic             c_out;
  logic             zero;
  logic [1:0]       state_dbg;
`ifdef ALU_OVF_FLAG_EN
  logic             ovf;

  modport master (output start, a, b, c_in, op, m,
                  input  busy, done, s, s_hi, c_out, zero, state_dbg, ovf);
  modport slave  (input  start, a, b, c_in, op, m,
                  output busy, done, s, s_hi, c_out, zero, state_dbg, ovf);
`else
  modport master (output start, a, b, c_in, op, m,
                  input  busy, done, s, s_hi, c_out, zero, state_dbg);
  modport slave  (input  start, a, b, c_in, op, m,
                  output busy, done, s, s_hi, c_out, zero, state_dbg);
`endif
endinterface

// File: rtl/seq_alu_unit.sv
// Registered ALU with 8 logic / 8 arithmetic ops and a WIDTH-cycle shift-add multiply.
// Optional signed-overflow flag enabled by defining ALU_OVF_FLAG_EN.
module seq_alu_unit #(
  parameter int WIDTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  seq_alu_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    MUL  = 2'd2
  } state_t;

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

  state_t           state, state_nx;
  logic [CW-1:0]    iter;
  logic [WIDTH-1:0] mul_a, mul_hi, mul_lo;
  logic [WIDTH-1:0] s_q, s_hi_q;
  logic             c_q, zero_q, done_q;

  logic             accept, is_mul;
  logic [WIDTH-1:0] r_s;
  logic             r_c, r_ovf;
  logic [WIDTH:0]   add_w, sub_w, add_sx, sub_sx, mul_sum;
  logic [WIDTH-1:0] mul_hi_nx, mul_lo_nx;

  // The done cycle of a single-cycle op still accepts a new start (back-to-back).
  assign accept = bus.start && (state != MUL);
  assign is_mul = !bus.m && (bus.op == 3'b110);

  always_comb begin
    state_nx = state;
    case (state)
      IDLE, EXEC: begin
        if (accept) state_nx = is_mul ? MUL : EXEC;
        else        state_nx = IDLE;
      end
      MUL:     if (iter == LAST_ITER) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Unsigned carry/borrow use zero-extension; signed overflow uses sign-extension.
  always_comb begin
    add_w  = {1'b0, bus.a} + {1'b0, bus.b} + {{WIDTH{1'b0}}, bus.c_in};
    sub_w  = {1'b0, bus.a} - {1'b0, bus.b} - {{WIDTH{1'b0}}, bus.c_in};
    add_sx = {bus.a[WIDTH-1], bus.a} + {bus.b[WIDTH-1], bus.b} + {{WIDTH{1'b0}}, bus.c_in};
    sub_sx = {bus.a[WIDTH-1], bus.a} - {bus.b[WIDTH-1], bus.b} - {{WIDTH{1'b0}}, bus.c_in};
    r_s    = '0;
    r_c    = 1'b0;
    r_ovf  = 1'b0;
    if (bus.m) begin
      case (bus.op)
        3'b000:  r_s = bus.a & bus.b;
        3'b001:  r_s = bus.a | bus.b;
        3'b010:  r_s = bus.a ^ bus.b;
        3'b011:  r_s = ~(bus.a & bus.b);
        3'b100:  r_s = ~(bus.a | bus.b);
        3'b101:  r_s = ~(bus.a ^ bus.b);
        3'b110:  r_s = ~bus.a;
        default: r_s = bus.b;
      endcase
    end else begin
      case (bus.op)
        3'b000: begin
          r_s   = add_w[WIDTH-1:0];
          r_c   = add_w[WIDTH];
          r_ovf = add_sx[WIDTH] ^ add_sx[WIDTH-1];
        end
        3'b001: begin
          r_s   = sub_w[WIDTH-1:0];
          r_c   = sub_w[WIDTH];
          r_ovf = sub_sx[WIDTH] ^ sub_sx[WIDTH-1];
        end
        3'b010: begin
          r_s   = bus.a + WIDTH'(1);
          r_c   = &bus.a;
          r_ovf = (bus.a == {1'b0, {(WIDTH-1){1'b1}}});
        end
        3'b011: begin
          r_s   = bus.a - WIDTH'(1);
          r_c   = ~|bus.a;
          r_ovf = (bus.a == {1'b1, {(WIDTH-1){1'b0}}});
        end
        3'b100: begin
          r_s = {bus.a[WIDTH-2:0], 1'b0};
          r_c = bus.a[WIDTH-1];
        end
        3'b101: begin
          r_s = {1'b0, bus.a[WIDTH-1:1]};
          r_c = bus.a[0];
        end
        3'b111:  r_s = {{(WIDTH-1){1'b0}}, (bus.a < bus.b)};
        default: r_s = '0;
      endcase
    end
  end

  // One shift-add step: conditionally add multiplicand into the high half, then shift right.
  always_comb begin
    mul_sum   = {1'b0, mul_hi} + (mul_lo[0] ? {1'b0, mul_a} : {(WIDTH+1){1'b0}});
    mul_hi_nx = mul_sum[WIDTH:1];
    mul_lo_nx = {mul_sum[0], mul_lo[WIDTH-1:1]};
  end

`ifdef ALU_OVF_FLAG_EN
  logic ovf_q;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      iter   <= '0;
      mul_a  <= '0;
      mul_hi <= '0;
      mul_lo <= '0;
      s_q    <= '0;
      s_hi_q <= '0;
      c_q    <= 1'b0;
      zero_q <= 1'b0;
      done_q <= 1'b0;
`ifdef ALU_OVF_FLAG_EN
      ovf_q  <= 1'b0;
`endif
    end else begin
      state  <= state_nx;
      done_q <= 1'b0;
      if (accept) begin
        if (is_mul) begin
          mul_a  <= bus.a;
          mul_hi <= '0;
          mul_lo <= bus.b;
          iter   <= '0;
        end else begin
          s_q    <= r_s;
          s_hi_q <= '0;
          c_q    <= r_c;
          zero_q <= (r_s == '0);
          done_q <= 1'b1;
`ifdef ALU_OVF_FLAG_EN
          ovf_q  <= r_ovf;
`endif
        end
      end else if (state == MUL) begin
        mul_hi <= mul_hi_nx;
        mul_lo <= mul_lo_nx;
        iter   <= iter + CW'(1);
        if (iter == LAST_ITER) begin
          s_q    <= mul_lo_nx;
          s_hi_q <= mul_hi_nx;
          c_q    <= |mul_hi_nx;
          zero_q <= (mul_lo_nx == '0);
          done_q <= 1'b1;
`ifdef ALU_OVF_FLAG_EN
          ovf_q  <= 1'b0;
`endif
        end
      end
    end
  end

`ifdef ALU_OVF_FLAG_EN
  assign bus.ovf = ovf_q;
`else
  logic unused_ovf;
  assign unused_ovf = r_ovf;
`endif

  assign bus.busy      = (state == EXEC) || (state == MUL);
  assign bus.done      = done_q;
  assign bus.s         = s_q;
  assign bus.s_hi      = s_hi_q;
  assign bus.c_out     = c_q;
  assign bus.zero      = zero_q;
  assign bus.state_dbg = state;

endmodule

// File: tb/tb_seq_alu_unit.sv
// Bench for seq_alu_unit (WIDTH=4): integer reference model, per-cycle compare, directed literal cases.
// Build with ALU_OVF_FLAG_EN defined to also cover the ovf flag.
module tb_seq_alu_unit;
  localparam int W = 4;
  localparam int MASK = (1 << W) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;

  seq_alu_if #(.WIDTH(W)) bus ();

  seq_alu_unit #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    int s; int hi; int c; int ov;
    bit mul; int n; int done_cyc;
  } op_t;

  function automatic int sx(input int v);
    return (v >= (1 << (W-1))) ? v - (1 << W) : v;
  endfunction

  function automatic bit out_of_range(input int v);
    return (v > (1 << (W-1)) - 1) || (v < -(1 << (W-1)));
  endfunction

  function automatic op_t compute(input bit mm, input int o, input int av, input int bv, input int ci);
    op_t r;
    int full;
    r.s = 0; r.hi = 0; r.c = 0; r.ov = 0; r.mul = 1'b0; r.n = 0; r.done_cyc = 0;
    if (mm) begin
      case (o)
        0: r.s = av & bv;
        1: r.s = av | bv;
        2: r.s = av ^ bv;
        3: r.s = ~(av & bv) & MASK;
        4: r.s = ~(av | bv) & MASK;
        5: r.s = ~(av ^ bv) & MASK;
        6: r.s = ~av & MASK;
        default: r.s = bv;
      endcase
    end else begin
      case (o)
        0: begin full = av + bv + ci; r.s = full & MASK; r.c = int'(full > MASK);
                 r.ov = int'(out_of_range(sx(av) + sx(bv) + ci)); end
        1: begin full = av - bv - ci; r.s = full & MASK; r.c = int'(av < bv + ci);
                 r.ov = int'(out_of_range(sx(av) - sx(bv) - ci)); end
        2: begin r.s = (av + 1) & MASK; r.c = int'(av == MASK); r.ov = int'(out_of_range(sx(av) + 1)); end
        3: begin r.s = (av - 1) & MASK; r.c = int'(av == 0);    r.ov = int'(out_of_range(sx(av) - 1)); end
        4: begin r.s = (av * 2) & MASK; r.c = av / (1 << (W-1)); end
        5: begin r.s = av / 2; r.c = av % 2; end
        6: begin full = av * bv; r.s = full % (1 << W); r.hi = full / (1 << W);
                 r.c = int'(r.hi != 0); r.mul = 1'b1; end
        default: r.s = int'(av < bv);
      endcase
    end
    return r;
  endfunction

  int  edge_n = 0;
  bit  pend_valid = 1'b0;
  op_t pend;

  // An op is taken at edge E unless an earlier op's done cycle lies beyond E.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_valid <= 1'b0;
    end else begin
      int e;
      op_t r;
      e = edge_n + 1;
      edge_n <= e;
      if (bus.start === 1'b1 && (!pend_valid || pend.done_cyc <= e)) begin
        r = compute(bus.m, int'(bus.op), int'(bus.a), int'(bus.b), int'(bus.c_in));
        r.n = e;
        r.done_cyc = r.mul ? e + W + 1 : e + 1;
        pend <= r;
        pend_valid <= 1'b1;
      end
    end
  end

  bit cmp_on = 1'b0;
  int h_s = 0, h_hi = 0, h_c = 0, h_z = 0, h_ov = 0;

  initial begin
    forever begin
      @(negedge clk);
      if (cmp_on) begin
        int  cyc;
        bit  eb, ed;
        cyc = edge_n + 1;
        eb = 1'b0; ed = 1'b0;
        if (rst) begin
          h_s = 0; h_hi = 0; h_c = 0; h_z = 0; h_ov = 0;
        end else if (pend_valid) begin
          ed = (cyc == pend.done_cyc);
          eb = (cyc > pend.n) && (pend.mul ? (cyc <= pend.n + W) : (cyc == pend.n + 1));
          if (ed) begin
            h_s = pend.s; h_hi = pend.hi; h_c = pend.c; h_ov = pend.ov; h_z = int'(pend.s == 0);
          end
        end
        chk("busy",  32'(bus.busy),  32'(eb));
        chk("done",  32'(bus.done),  32'(ed));
        chk("s",     32'(bus.s),     32'(h_s));
        chk("s_hi",  32'(bus.s_hi),  32'(h_hi));
        chk("c_out", 32'(bus.c_out), 32'(h_c));
        chk("zero",  32'(bus.zero),  32'(h_z));
`ifdef ALU_OVF_FLAG_EN
        chk("ovf",   32'(bus.ovf),   32'(h_ov));
`endif
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input bit mm, input int o, input int av, input int bv, input int ci);
    bus.m = mm; bus.op = 3'(o); bus.a = W'(av); bus.b = W'(bv); bus.c_in = ci[0];
  endtask

  // Launch one op at a negedge and wait (bounded) for its done cycle.
  task automatic do_op(input string name, input bit mm, input int o, input int av, input int bv, input int ci);
    bit seen;
    seen = 1'b0;
    drive(mm, o, av, bv, ci);
    bus.start = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      bus.start = 1'b0;
      if (bus.done === 1'b1) begin seen = 1'b1; break; end
    end
    chk({name, "_done_seen"}, 32'(seen), 32'd1);
  endtask

  task automatic pulse_reset();
    #2 rst = 1'b1;
    #1;
    chk("rst_busy",  32'(bus.busy),  32'd0);
    chk("rst_done",  32'(bus.done),  32'd0);
    chk("rst_s",     32'(bus.s),     32'd0);
    chk("rst_s_hi",  32'(bus.s_hi),  32'd0);
    chk("rst_c_out", 32'(bus.c_out), 32'd0);
    chk("rst_zero",  32'(bus.zero),  32'd0);
    @(negedge clk);
    #2 rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    bus.start = 1'b0;
    drive(1'b0, 0, 0, 0, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    cmp_on = 1'b1;
    @(negedge clk);

    // 1: reset mid-operation, then idle
    do_op("pre", 1'b0, 0, 9, 4, 1);
    drive(1'b0, 6, 7, 7, 0);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    pulse_reset();
    @(negedge clk);
    chk("idle_busy", 32'(bus.busy), 32'd0);
    chk("idle_done", 32'(bus.done), 32'd0);

    // 2-3: logic and arithmetic literals
    do_op("xnor", 1'b1, 5, 15, 15, 0);
    chk("xnor_s", 32'(bus.s), 32'hF); chk("xnor_c", 32'(bus.c_out), 32'd0); chk("xnor_z", 32'(bus.zero), 32'd0);
    do_op("add", 1'b0, 0, 15, 1, 0);
    chk("add_s", 32'(bus.s), 32'h0); chk("add_c", 32'(bus.c_out), 32'd1); chk("add_z", 32'(bus.zero), 32'd1);
    do_op("sub", 1'b0, 1, 3, 5, 0);
    chk("sub_s", 32'(bus.s), 32'hE); chk("sub_c", 32'(bus.c_out), 32'd1);
`ifdef ALU_OVF_FLAG_EN
    chk("sub_ovf", 32'(bus.ovf), 32'd0);
    do_op("add_ov", 1'b0, 0, 7, 1, 0);
    chk("addov_s", 32'(bus.s), 32'h8); chk("addov_ovf", 32'(bus.ovf), 32'd1);
`endif
    do_op("inc", 1'b0, 2, 15, 0, 0);
    chk("inc_s", 32'(bus.s), 32'h0); chk("inc_c", 32'(bus.c_out), 32'd1); chk("inc_z", 32'(bus.zero), 32'd1);
    do_op("dec", 1'b0, 3, 0, 0, 0);
    chk("dec_s", 32'(bus.s), 32'hF); chk("dec_c", 32'(bus.c_out), 32'd1);
    do_op("cmp", 1'b0, 7, 3, 5, 0);
    chk("cmp_s", 32'(bus.s), 32'h1); chk("cmp_hi", 32'(bus.s_hi), 32'h0);

    // 4: MUL F*F with an ignored start during busy
    drive(1'b0, 6, 15, 15, 0);
    bus.start = 1'b1;
    for (int k = 1; k <= W + 1; k++) begin
      @(negedge clk);
      if (k == 2) begin drive(1'b0, 0, 1, 1, 0); bus.start = 1'b1; end
      else bus.start = 1'b0;
      chk("mul_busy", 32'(bus.busy), 32'(k <= W));
      chk("mul_done", 32'(bus.done), 32'(k == W + 1));
    end
    chk("mul_s", 32'(bus.s), 32'h1); chk("mul_hi", 32'(bus.s_hi), 32'hE); chk("mul_c", 32'(bus.c_out), 32'd1);

    // back-to-back: start held through the done cycle of a single-cycle op
    drive(1'b1, 0, 12, 10, 0);
    bus.start = 1'b1;
    @(negedge clk);
    chk("b2b_done1", 32'(bus.done), 32'd1); chk("b2b_s1", 32'(bus.s), 32'h8);
    drive(1'b1, 1, 1, 2, 0);
    @(negedge clk);
    bus.start = 1'b0;
    chk("b2b_done2", 32'(bus.done), 32'd1); chk("b2b_s2", 32'(bus.s), 32'h3);
    @(negedge clk);

    // 5: reset during MUL, then ADD 2+3
    drive(1'b0, 6, 5, 6, 0);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    pulse_reset();
    repeat (W + 2) @(negedge clk);
    do_op("add23", 1'b0, 0, 2, 3, 0);
    chk("add23_s", 32'(bus.s), 32'h5);

    // randomized traffic with occasional async reset
    for (int i = 0; i < 600; i++) begin
      drive(1'($urandom_range(0, 1)), int'($urandom_range(0, 7)), int'($urandom_range(0, MASK)),
            int'($urandom_range(0, MASK)), int'($urandom_range(0, 1)));
      bus.start = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 99) == 0) begin
        pulse_reset();
      end
      @(negedge clk);
    end
    bus.start = 1'b0;
    repeat (W + 3) @(negedge clk);

    cmp_on = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
